// File: rtl/dot11_rx_ctrl.sv
// Receive-path sequencer for the dot11 core: settings registers, per-packet
// reset/enable sequencing with watchdogs, completion status and counters.
module dot11_rx_ctrl #(
  parameter int          FLUSH_CYCLES     = 4,
  parameter logic [15:0] SIG_TIMEOUT_DEF  = 16'd2000,
  parameter logic [23:0] DATA_TIMEOUT_DEF = 24'd1000000,
  parameter logic [31:0] MIN_PLATEAU_DEF  = 32'd100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        long_preamble_detected,
  input  logic        legacy_sig_stb,
  input  logic [3:0]  legacy_rate,
  input  logic        legacy_sig_rsvd,
  input  logic [11:0] legacy_len,
  input  logic        legacy_sig_parity,
  input  logic [5:0]  legacy_sig_tail,
  input  logic        fcs_out_strobe,
  input  logic        fcs_ok,
  output logic        rx_reset,
  output logic        rx_enable,
  output logic [10:0] power_thres,
  output logic [31:0] min_plateau,
  output logic        soft_decoding,
  output logic [2:0]  state,
  output logic        pkt_done,
  output logic [2:0]  pkt_status,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_err_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_WAIT_SIG = 3'd2;
  localparam logic [2:0] S_WAIT_FCS = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_FCS_ERR  = 3'd1;
  localparam logic [2:0] ST_SIG_ERR  = 3'd2;
  localparam logic [2:0] ST_SIG_TO   = 3'd3;
  localparam logic [2:0] ST_DATA_TO  = 3'd4;
  localparam logic [2:0] ST_ABORT    = 3'd5;

  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);

  logic        rx_en_q, soft_q;
  logic [10:0] power_q;
  logic [31:0] plateau_q;
  logic [15:0] sig_to_q;
  logic [23:0] data_to_q;

  logic [2:0]  state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [15:0] flush_q, flush_d;
  logic        done_q, done_d;
  logic [2:0]  status_q, status_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        finish;
  logic [2:0]  fin_status;
  logic        cnt_clr;
  logic        sig_valid;

  assign cnt_clr   = set_stb && (set_addr == 8'd5);
  // Even parity over rate/rsvd/len/parity, plus the fixed-value fields.
  assign sig_valid = ~(^{legacy_rate, legacy_sig_rsvd, legacy_len, legacy_sig_parity})
                     & legacy_rate[3] & ~legacy_sig_rsvd & (legacy_sig_tail == 6'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_en_q   <= 1'b0;
      soft_q    <= 1'b1;
      power_q   <= 11'd0;
      plateau_q <= MIN_PLATEAU_DEF;
      sig_to_q  <= SIG_TIMEOUT_DEF;
      data_to_q <= DATA_TIMEOUT_DEF;
    end else if (set_stb) begin
      case (set_addr)
        8'd0: begin
          rx_en_q <= set_data[0];
          soft_q  <= set_data[1];
        end
        8'd1:    power_q   <= set_data[10:0];
        8'd2:    plateau_q <= set_data;
        8'd3:    sig_to_q  <= set_data[15:0];
        8'd4:    data_to_q <= set_data[23:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    flush_d    = flush_q;
    done_d     = 1'b0;
    status_d   = status_q;
    finish     = 1'b0;
    fin_status = ST_OK;
    case (state_q)
      S_IDLE: if (rx_en_q) state_d = S_ARMED;
      S_ARMED: begin
        if (long_preamble_detected) begin
          state_d = S_WAIT_SIG;
          timer_d = {8'd0, sig_to_q};
        end else if (!rx_en_q) begin
          state_d = S_FLUSH;
          flush_d = FLUSH_LAST;
        end
      end
      S_WAIT_SIG: begin
        timer_d = timer_q - 24'd1;
        if (legacy_sig_stb) begin
          if (sig_valid) begin
            state_d = S_WAIT_FCS;
            timer_d = data_to_q;
          end else begin
            finish     = 1'b1;
            fin_status = ST_SIG_ERR;
          end
        end else if (!rx_en_q) begin
          finish     = 1'b1;
          fin_status = ST_ABORT;
        end else if (timer_q == 24'd0) begin
          finish     = 1'b1;
          fin_status = ST_SIG_TO;
        end
      end
      S_WAIT_FCS: begin
        timer_d = timer_q - 24'd1;
        if (fcs_out_strobe) begin
          finish     = 1'b1;
          fin_status = fcs_ok ? ST_OK : ST_FCS_ERR;
        end else if (!rx_en_q) begin
          finish     = 1'b1;
          fin_status = ST_ABORT;
        end else if (timer_q == 24'd0) begin
          finish     = 1'b1;
          fin_status = ST_DATA_TO;
        end
      end
      S_FLUSH: begin
        if (flush_q == 16'd0) state_d = rx_en_q ? S_ARMED : S_IDLE;
        else                  flush_d = flush_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (finish) begin
      state_d  = S_FLUSH;
      flush_d  = FLUSH_LAST;
      done_d   = 1'b1;
      status_d = fin_status;
    end

    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (finish && fin_status == ST_OK && ok_cnt_q != 16'hFFFF)
      ok_cnt_d = ok_cnt_q + 16'd1;
    if (finish && fin_status != ST_OK && fin_status != ST_ABORT && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
    // A clear on the same edge as an increment leaves the counters at zero.
    if (cnt_clr) begin
      ok_cnt_d  = 16'd0;
      err_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      timer_q   <= 24'd0;
      flush_q   <= 16'd0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      ok_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
      status_q  <= status_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rx_reset      = (state_q == S_IDLE) || (state_q == S_FLUSH);
  assign rx_enable     = (state_q == S_ARMED) || (state_q == S_WAIT_SIG) || (state_q == S_WAIT_FCS);
  assign power_thres   = power_q;
  assign min_plateau   = plateau_q;
  assign soft_decoding = soft_q;
  assign state         = state_q;
  assign pkt_done      = done_q;
  assign pkt_status    = status_q;
  assign pkt_ok_cnt    = ok_cnt_q;
  assign pkt_err_cnt   = err_cnt_q;

endmodule

// File: doc/dot11_rx_ctrl.md
# dot11_rx_ctrl

Receive-path sequencer for the `dot11` receiver core. It owns the core's runtime settings (power threshold, plateau length, soft decoding) through the settings bus and drives the core's reset and enable per packet. It supervises each packet through preamble, SIGNAL and FCS with watchdog timeouts. It also reports a per-packet completion status and keeps saturating ok/error counters.

## Interface
Parameters:
- FLUSH_CYCLES, 4, cycles `rx_reset` is held high between packets (≥1)
- SIG_TIMEOUT_DEF, 16'd2000, reset value of the SIGNAL watchdog register
- DATA_TIMEOUT_DEF, 24'd1000000, reset value of the data/FCS watchdog register
- MIN_PLATEAU_DEF, 32'd100, reset value of `min_plateau`

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rstn  in  1  asynchronous, active-low reset
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- long_preamble_detected  in  1  from core
- legacy_sig_stb  in  1  from core
- legacy_rate  in  4  from core
- legacy_sig_rsvd  in  1  from core
- legacy_len  in  12  from core
- legacy_sig_parity  in  1  from core
- legacy_sig_tail  in  6  from core
- fcs_out_strobe  in  1  from core
- fcs_ok  in  1  from core
- rx_reset  out  1  core reset, active-high; reset value 1
- rx_enable  out  1  core enable; reset value 0
- power_thres  out  11  reset value 0
- min_plateau  out  32  reset value MIN_PLATEAU_DEF
- soft_decoding  out  1  reset value 1
- state  out  3  FSM state; reset value S_IDLE (0)
- pkt_done  out  1  one-cycle completion pulse; reset value 0
- pkt_status  out  3  status of last packet; reset value 0
- pkt_ok_cnt  out  16  reset value 0
- pkt_err_cnt  out  16  reset value 0

## Operation
- Settings registers are written on the clock edge where `set_stb`=1; unknown addresses are ignored.
  - 0: bit0 `rx_en`, bit1 `soft_decoding`.
  - 1: `power_thres` = data[10:0].
  - 2: `min_plateau`.
  - 3: `sig_timeout` = data[15:0].
  - 4: `data_timeout` = data[23:0].
  - 5: clear both counters; data is ignored.
- `rx_en` resets to 0. Setting outputs come straight from the registers.
- States: S_IDLE=0, S_ARMED=1, S_WAIT_SIG=2, S_WAIT_FCS=3, S_FLUSH=4.
- `rx_reset`=1 in S_IDLE and S_FLUSH, 0 otherwise. `rx_enable`=1 in S_ARMED, S_WAIT_SIG and S_WAIT_FCS.
- S_IDLE → S_ARMED when `rx_en`=1.
- S_ARMED:
  - `long_preamble_detected` → S_WAIT_SIG, and the timer is loaded with `sig_timeout`.
  - `rx_en`=0 → S_FLUSH. No `pkt_done`.
- S_WAIT_SIG:
  - On `legacy_sig_stb`, the SIGNAL field is valid iff the XOR over rate, rsvd, len and parity is 0, rate[3]=1, rsvd=0 and tail=0.
  - Valid SIGNAL → S_WAIT_FCS, and the timer is loaded with `data_timeout`.
  - Invalid SIGNAL → S_FLUSH with status SIG_ERR.
- S_WAIT_FCS: `fcs_out_strobe` → S_FLUSH with status OK if `fcs_ok`, else FCS_ERR.
- Watchdog timer:
  - Decrements every cycle while in a WAIT state.
  - If it reads 0 with no event, the FSM goes to S_FLUSH with status SIG_TIMEOUT (from S_WAIT_SIG) or DATA_TIMEOUT (from S_WAIT_FCS).
  - With load value N, a WAIT state lasts at most N+1 cycles.
- Clearing `rx_en` while in a WAIT state → S_FLUSH with status ABORT.
- Priority within a WAIT state: completion event > abort > timeout.
- S_FLUSH:
  - Lasts exactly FLUSH_CYCLES cycles.
  - Then → S_ARMED if `rx_en`=1, else S_IDLE.
- Status codes: 0 OK, 1 FCS_ERR, 2 SIG_ERR, 3 SIG_TIMEOUT, 4 DATA_TIMEOUT, 5 ABORT.
- `pkt_done` and `pkt_status`: every WAIT→FLUSH transition pulses `pkt_done` and updates `pkt_status`. `pkt_status` holds until the next pulse.
- Counters:
  - OK increments `pkt_ok_cnt`. Statuses 1–4 increment `pkt_err_cnt`. ABORT counts nowhere.
  - Both counters saturate at 16'hFFFF.
  - A clear that coincides with an increment wins: the result is 0.

## Timing
- Settings take effect at outputs 1 cycle after the `set_stb` edge.
- All state transitions are registered: an input event at cycle t changes `state` and `rx_reset`/`rx_enable` at t+1.
- `pkt_done`, `pkt_status` and counter updates appear in the same cycle that `state` first shows S_FLUSH.
- After reset deassertion, the FSM sits in S_IDLE until the first `rx_en` write. It reaches S_ARMED 2 cycles after the `set_stb` edge (register, then FSM).
- Asserting `rstn`=0 at any time, including mid-packet:
  - Immediately forces all outputs to their reset values.
  - Restores all settings to defaults.
  - Produces no `pkt_done`.
- Core strobes are ignored in states where they are not expected; for example, `fcs_out_strobe` in S_ARMED has no effect.

## Test plan
- Reset, then write addr 0 = 3 → `rx_reset` falls and `state`=1 two cycles after the write; `min_plateau`=100 and `power_thres`=0 before any write.
- Long preamble, valid SIGNAL (rate 4'b1011, len 100, correct parity), `fcs_out_strobe` with `fcs_ok`=1 → `pkt_done` pulses once with `pkt_status`=0, `pkt_ok_cnt`=1, `rx_reset` high for exactly 4 cycles, then `state`=1.
- SIGNAL with a flipped parity bit → `pkt_status`=2, `pkt_err_cnt`=1; no transition to S_WAIT_FCS.
- `sig_timeout`=10, preamble with no SIGNAL → `pkt_done` exactly 11 cycles after entering S_WAIT_SIG, status 3. Repeat with `data_timeout`=5 and no FCS → status 4.
- Write addr 0 = 0 while in S_WAIT_FCS → status 5, counters unchanged, FLUSH lasts 4 cycles, then `state`=0. Check that an FCS event in the same cycle as the write gives status OK instead.
- Preload `pkt_err_cnt` to 16'hFFFF via repeated errors → stays FFFF; addr 5 write coincident with an OK completion → both counters 0.
